// File: rtl/seed_capture_if.sv
// Seed handoff channel from seed_capture to the grid loader.
// Valid/ready handshake carrying one WIDTH-bit board seed.
interface seed_capture_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] seed_out;
  logic             seed_valid;
  logic             seed_ready;

  modport master (
    output seed_out,
    output seed_valid,
    input  seed_ready
  );

  modport slave (
    input  seed_out,
    input  seed_valid,
    output seed_ready
  );
endinterface

// File: rtl/seed_capture.sv
// Button-triggered LFSR sampler: stir, sample, reject degenerate
// states, then offer the seed to the grid loader.
module seed_capture #(
  parameter int WIDTH       = 64,
  parameter int STIR_CYCLES = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      rand_in,
  input  logic                  capture_btn,
  seed_capture_if.master        seed,
  output logic                  busy,
  output logic [7:0]            reject_count
);

  typedef enum logic [1:0] {
    IDLE,
    STIR,
    SAMPLE,
    HOLD
  } state_t;

  localparam logic [7:0] STIR_LOAD = 8'(STIR_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  logic                   btn_p;
  logic                   btn_edge;

  state_t           state_q, state_n;
  logic [7:0]       cnt_q, cnt_n;
  logic [WIDTH-1:0] seed_q, seed_n;
  logic [7:0]       rej_q, rej_n;
  logic             valid_q;
  logic             busy_q;
  logic             degenerate;

  assign btn_s    = sync_q[SYNC_STAGES-1];
  assign btn_edge = btn_s & ~btn_p;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      btn_p  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], capture_btn};
      btn_p  <= btn_s;
    end
  end

  // All-ones is the XNOR lockup state; all-zeros is an empty board.
  assign degenerate = (rand_in == '0) || (rand_in == '1);

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    seed_n  = seed_q;
    rej_n   = rej_q;
    unique case (state_q)
      IDLE: begin
        if (btn_edge) begin
          cnt_n   = STIR_LOAD;
          state_n = STIR;
        end
      end
      STIR: begin
        if (cnt_q == 8'd0) begin
          state_n = SAMPLE;
        end else begin
          cnt_n = cnt_q - 8'd1;
        end
      end
      SAMPLE: begin
        if (!degenerate) begin
          seed_n  = rand_in;
          state_n = HOLD;
        end else begin
          if (rej_q != 8'hFF) begin
            rej_n = rej_q + 8'd1;
          end
          cnt_n   = STIR_LOAD;
          state_n = STIR;
        end
      end
      HOLD: begin
        if (seed.seed_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      seed_q  <= '0;
      rej_q   <= 8'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      seed_q  <= seed_n;
      rej_q   <= rej_n;
      valid_q <= (state_n == HOLD);
      busy_q  <= (state_n != IDLE);
    end
  end

  assign seed.seed_out   = seed_q;
  assign seed.seed_valid = valid_q;
  assign busy            = busy_q;
  assign reject_count    = rej_q;

endmodule

// File: tb/tb_seed_capture.sv
// Directed and randomized checks of seed_capture against
// a cycle-count model of press-to-seed timing.
module tb_seed_capture;
  localparam int W  = 64;
  localparam int S  = 16;
  localparam int SY = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] rand_in;
  logic         capture_btn;
  logic         busy;
  logic [7:0]   reject_count;

  seed_capture_if #(.WIDTH(W)) sif ();

  seed_capture #(
    .WIDTH(W),
    .STIR_CYCLES(S),
    .SYNC_STAGES(SY)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rand_in(rand_in),
    .capture_btn(capture_btn),
    .seed(sif),
    .busy(busy),
    .reject_count(reject_count)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_seed;
  int           exp_rej;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [W-1:0] good64();
    logic [W-1:0] v;
    v = rnd64();
    while (v == '0 || v == '1) v = rnd64();
    return v;
  endfunction

  // One press at step 1; sample k lands SY+S+2+k*(S+1) steps later.
  task automatic capture(input int nrej, input logic [W-1:0] badv,
                         input logic [W-1:0] goodv, input int bp,
                         input int hold, input int rep1, input int rep2);
    int vidx, done, last, first_s, rej;
    logic [W-1:0] prev;
    prev    = exp_seed;
    rej     = exp_rej;
    first_s = SY + S + 2;
    vidx    = first_s + nrej * (S + 1);
    done    = vidx + bp + 1;
    last    = done;
    if (hold > last) last = hold;
    if (rep1 + 3 > last) last = rep1 + 3;
    if (rep2 + 3 > last) last = rep2 + 3;
    last = last + 4;
    for (int i = 1; i <= last; i++) begin
      capture_btn = (i <= hold)
        || (rep1 > 0 && i >= rep1 && i < rep1 + 3)
        || (rep2 > 0 && i >= rep2 && i < rep2 + 3);
      sif.seed_ready = (bp == 0) || (i >= vidx + bp + 1);
      rand_in = rnd64();
      if (i >= first_s && i <= vidx && ((i - first_s) % (S + 1)) == 0) begin
        if (i == vidx) begin
          rand_in = goodv;
        end else begin
          rand_in = badv;
          if (rej < 255) rej++;
        end
      end
      step();
      chk("seed_valid", sif.seed_valid, (i >= vidx && i < done));
      chk("busy", busy, (i >= SY + 1 && i < done));
      chk("seed_out", sif.seed_out, (i >= vidx) ? goodv : prev);
      chk("reject_count", reject_count, rej);
    end
    capture_btn = 1'b0;
    exp_seed = goodv;
    exp_rej  = rej;
  endtask

  initial begin
    reset          = 1'b1;
    capture_btn    = 1'b0;
    sif.seed_ready = 1'b0;
    rand_in        = '0;
    exp_seed       = '0;
    exp_rej        = 0;
    step();
    step();
    chk("rst_seed_out", sif.seed_out, '0);
    chk("rst_seed_valid", sif.seed_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_reject_count", reject_count, 0);
    reset = 1'b0;
    step();

    capture(0, '0, 64'h0123_4567_89AB_CDEF, 0, 1, 0, 0);
    capture(0, '0, good64(), 10, 1, 0, 0);
    capture(1, '1, 64'h5, 0, 1, 0, 0);
    capture(1, '0, 64'h5, 0, 1, 0, 0);

    capture_btn = 1'b1;
    step();
    capture_btn = 1'b0;
    for (int i = 2; i <= SY + 1 + 5; i++) step();
    chk("busy_pre_reset", busy, 1);
    reset = 1'b1;
    #1;
    chk("midrst_seed_out", sif.seed_out, '0);
    chk("midrst_seed_valid", sif.seed_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_reject_count", reject_count, 0);
    step();
    step();
    reset    = 1'b0;
    exp_seed = '0;
    exp_rej  = 0;
    step();
    capture(0, '0, good64(), 0, 1, 0, 0);

    capture(0, '0, good64(), 10, 1, SY + 5, SY + S + 3);
    capture(0, '0, good64(), 0, 100, 0, 0);

    for (int k = 0; k < 4; k++) begin
      capture(int'($urandom_range(0, 2)),
              ($urandom_range(0, 1) == 1) ? '1 : '0,
              good64(), int'($urandom_range(0, 5)), 1, 0, 0);
    end

    capture(300, '1, good64(), 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
